amo_responder: RTL and testbench
================================

AMO_RESPONDER -- requirements
Module: amo_responder

Interface
REQ-001 The block SHALL have parameter RESV_LSB, default 3, meaning the number of address LSBs ignored in the LR/SC reservation compare.
REQ-002 The block SHALL have port clk_i, input, 1 bit, clock; the block is rising-edge clocked.
REQ-003 The block SHALL have port rst_ni, input, 1 bit, reset; reset is asynchronous, active-low.
REQ-004 The block SHALL have the following AMO request ports:
- amo_req_i, input, 1 bit: request, held high until ack.
- amo_op_i, input, amo_t: operation.
- amo_size_i, input, 2 bits: 2'b10 is word, 2'b11 is double.
- amo_addr_i, input, 64 bits: physical address.
- amo_data_i, input, 64 bits: operand.
REQ-005 The block SHALL have the following AMO response ports:
- amo_ack_o, output, 1 bit: one-cycle completion pulse.
- amo_result_o, output, 64 bits: result, valid with amo_ack_o.
REQ-006 The block SHALL have the following memory request ports:
- mem_req_o, output, 1 bit.
- mem_we_o, output, 1 bit.
- mem_addr_o, output, 64 bits: double-aligned.
- mem_be_o, output, 8 bits.
- mem_wdata_o, output, 64 bits.
- mem_gnt_i, input, 1 bit.
REQ-007 The block SHALL have the following memory response ports:
- mem_rvalid_i, input, 1 bit.
- mem_rdata_i, input, 64 bits.

Function
REQ-008 The state machine SHALL have states IDLE, RD_REQ, RD_WAIT, WR_REQ and ACK.
REQ-009 Acceptance and capture:
- A request is accepted only in IDLE with amo_req_i=1.
- op, size, addr and data are captured at acceptance; later input changes are ignored.
REQ-010 On acceptance, the next state SHALL be:
- SC with LRSC enabled and a reservation hit: WR_REQ.
- SC with a reservation miss: ACK.
- Any other op: RD_REQ.
REQ-011 Memory request handshake:
- In RD_REQ and WR_REQ, mem_req_o=1.
- All mem_* request outputs are held stable until mem_gnt_i=1.
- mem_we_o=1 only in WR_REQ.
- Grant in RD_REQ goes to RD_WAIT; grant in WR_REQ goes to ACK.
REQ-012 In RD_WAIT, mem_rvalid_i=1 SHALL capture the old value, then go to ACK for LR, or to WR_REQ otherwise.
REQ-013 Word ops SHALL:
- Use mem_be_o=8'h0F when addr[2]=0 and 8'hF0 when addr[2]=1.
- Place the 32-bit result replicated in both halves of mem_wdata_o.
REQ-014 Double ops SHALL use mem_be_o=8'hFF.
REQ-015 Word ops SHALL compute on 32 bits:
- ADD wraps mod 2^32.
- MAX/MIN compare signed 32-bit; MAXU/MINU compare unsigned.
- The old value is sign-extended to 64 bits for the result.
REQ-016 SWAP SHALL write the operand; AND/OR/XOR/ADD/MAX/MIN/MAXU/MINU SHALL write op(old, operand).
REQ-017 amo_result_o SHALL be the old memory value for all ops except SC, which returns 0 on success and 1 on failure.
REQ-018 ACK SHALL last exactly one cycle: amo_ack_o=1, then IDLE; a new request is accepted no earlier than the cycle after ACK.
REQ-019 With zero-wait grant and rvalid one cycle after grant, ack SHALL occur, counted from the acceptance cycle N:
- RMW: N+4.
- LR: N+3.
- SC success: N+2.
- SC failure: N+1.
REQ-020 Reservation update:
- LR sets resv_valid and resv_addr=addr[63:RESV_LSB] when its read completes.
- Every SC clears resv_valid at its ack, whether it succeeds or fails.
- Any write granted to the reserved granule clears resv_valid.
REQ-021 amo_op_i=AMO_NONE accepted in IDLE SHALL be acked next cycle with result 0 and no memory access.
REQ-022 amo_result_o SHALL be 0 whenever amo_ack_o=0.

Reset
REQ-023 While rst_ni=0, the block SHALL hold:
- state in IDLE.
- resv_valid=0.
- mem_req_o=0, mem_we_o=0, amo_ack_o=0.
- all data outputs and registers at 0.
REQ-024 Reset asserted mid-transaction SHALL abandon it immediately, with no ack and no further memory request; a late mem_rvalid_i after reset SHALL be ignored.

Configuration
REQ-025 With AMO_RESP_LRSC_EN defined, LR/SC SHALL behave as in REQ-010, REQ-017 and REQ-020.
REQ-026 Without AMO_RESP_LRSC_EN:
- No reservation register exists.
- LR behaves as a plain read returning the old value.
- SC always fails: result 1, ack at N+1, no memory write.

Verification
REQ-027 AMOADD.D, addr 0x1000, operand 5, memory 0x10 -> one read then a write of 0x15 with be 0xFF; result 0x10; ack at N+4.
REQ-028 AMOMAX.W, addr 0x1004, operand 0xFFFFFFFF, memory word 0x00000001 -> write 0x00000001 with be 0xF0; result 0x1.
REQ-029 AMOMAXU.W, same values as REQ-028 -> write 0xFFFFFFFF; result 0x1.
REQ-030 LR.D 0x2000, then SC.D 0x2000 data 7 -> SC result 0, memory written 7; a second SC.D -> result 1, no write.
REQ-031 LR.D 0x2000, then AMOSWAP.D 0x2000, then SC.D 0x2000 -> SC result 1, no write (with AMO_RESP_LRSC_EN); without the macro, LR.D returns the memory value and SC.D returns 1 with no write.
REQ-032 mem_gnt_i held low 5 cycles in RD_REQ -> mem_* outputs stable for those cycles; rst_ni pulsed in RD_WAIT -> no ack; a later rvalid is ignored; the next request completes normally.

Source files
------------

// File: rtl/amo_responder.sv
// Atomic memory operation responder: accepts one AMO at a time, performs the
// read-modify-write on a 64-bit memory port and returns the old value.
// Optional LR/SC reservation tracking is built when AMO_RESP_LRSC_EN is defined;
// otherwise LR is a plain read and SC always fails without touching memory.

package amo_pkg;
  typedef enum logic [3:0] {
    AMO_NONE, AMO_LR, AMO_SC, AMO_SWAP, AMO_ADD, AMO_AND, AMO_OR, AMO_XOR,
    AMO_MAX, AMO_MAXU, AMO_MIN, AMO_MINU
  } amo_t;
endpackage

module amo_responder
  import amo_pkg::*;
#(
  parameter int unsigned RESV_LSB = 3
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        amo_req_i,
  input  amo_t        amo_op_i,
  input  logic [1:0]  amo_size_i,
  input  logic [63:0] amo_addr_i,
  input  logic [63:0] amo_data_i,
  output logic        amo_ack_o,
  output logic [63:0] amo_result_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [63:0] mem_addr_o,
  output logic [7:0]  mem_be_o,
  output logic [63:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [63:0] mem_rdata_i
);

  typedef enum logic [2:0] {StIdle, StRdReq, StRdWait, StWrReq, StAck} state_e;

  state_e      state_q, state_d;
  amo_t        op_q;
  logic        dw_q;
  logic [63:0] addr_q, data_q, old_q;
  logic        sc_fail_q;
  logic        accept;
  logic        resv_hit;

  assign accept = (state_q == StIdle) && amo_req_i;

`ifdef AMO_RESP_LRSC_EN
  logic                  resv_valid_q;
  logic [63-RESV_LSB:0]  resv_addr_q;

  assign resv_hit = resv_valid_q && (amo_addr_i[63:RESV_LSB] == resv_addr_q);

  // Reservation: set by a completed LR read, dropped by any SC ack or a write to the granule
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      resv_valid_q <= 1'b0;
      resv_addr_q  <= '0;
    end else if (state_q == StRdWait && mem_rvalid_i && op_q == AMO_LR) begin
      resv_valid_q <= 1'b1;
      resv_addr_q  <= addr_q[63:RESV_LSB];
    end else if ((state_q == StAck && op_q == AMO_SC) ||
                 (state_q == StWrReq && mem_gnt_i && addr_q[63:RESV_LSB] == resv_addr_q)) begin
      resv_valid_q <= 1'b0;
    end
  end
`else
  logic [31:0] unused_resv_lsb;
  assign unused_resv_lsb = RESV_LSB;
  assign resv_hit        = 1'b0;
`endif

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^addr_q[1:0];

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // Request capture at acceptance; old value captured when the read returns
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q      <= AMO_NONE;
      dw_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      old_q     <= '0;
      sc_fail_q <= 1'b0;
    end else if (accept) begin
      op_q      <= amo_op_i;
      dw_q      <= (amo_size_i == 2'b11);
      addr_q    <= amo_addr_i;
      data_q    <= amo_data_i;
      old_q     <= '0;
      sc_fail_q <= ~resv_hit;
    end else if (state_q == StRdWait && mem_rvalid_i) begin
      old_q <= mem_rdata_i;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (amo_req_i) begin
          case (amo_op_i)
            AMO_NONE: state_d = StAck;
            AMO_SC:   state_d = resv_hit ? StWrReq : StAck;
            default:  state_d = StRdReq;
          endcase
        end
      end
      StRdReq:  if (mem_gnt_i) state_d = StRdWait;
      StRdWait: if (mem_rvalid_i) state_d = (op_q == AMO_LR) ? StAck : StWrReq;
      StWrReq:  if (mem_gnt_i) state_d = StAck;
      StAck:    state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  logic [31:0] old_w, opnd_w, res_w;
  logic [63:0] res_d, old_ext, wdata;

  assign old_w   = addr_q[2] ? old_q[63:32] : old_q[31:0];
  assign opnd_w  = data_q[31:0];
  assign old_ext = dw_q ? old_q : {{32{old_w[31]}}, old_w};
  assign wdata   = dw_q ? res_d : {res_w, res_w};

  // Word ALU; SWAP and SC write the operand
  always_comb begin
    res_w = opnd_w;
    case (op_q)
      AMO_ADD:  res_w = old_w + opnd_w;
      AMO_AND:  res_w = old_w & opnd_w;
      AMO_OR:   res_w = old_w | opnd_w;
      AMO_XOR:  res_w = old_w ^ opnd_w;
      AMO_MAX:  res_w = ($signed(old_w) > $signed(opnd_w)) ? old_w : opnd_w;
      AMO_MIN:  res_w = ($signed(old_w) < $signed(opnd_w)) ? old_w : opnd_w;
      AMO_MAXU: res_w = (old_w > opnd_w) ? old_w : opnd_w;
      AMO_MINU: res_w = (old_w < opnd_w) ? old_w : opnd_w;
      default:  res_w = opnd_w;
    endcase
  end

  // Double ALU
  always_comb begin
    res_d = data_q;
    case (op_q)
      AMO_ADD:  res_d = old_q + data_q;
      AMO_AND:  res_d = old_q & data_q;
      AMO_OR:   res_d = old_q | data_q;
      AMO_XOR:  res_d = old_q ^ data_q;
      AMO_MAX:  res_d = ($signed(old_q) > $signed(data_q)) ? old_q : data_q;
      AMO_MIN:  res_d = ($signed(old_q) < $signed(data_q)) ? old_q : data_q;
      AMO_MAXU: res_d = (old_q > data_q) ? old_q : data_q;
      AMO_MINU: res_d = (old_q < data_q) ? old_q : data_q;
      default:  res_d = data_q;
    endcase
  end

  // Outputs are decoded from state and captured registers, so they hold while waiting for grant
  always_comb begin
    mem_req_o    = (state_q == StRdReq) || (state_q == StWrReq);
    mem_we_o     = (state_q == StWrReq);
    mem_addr_o   = mem_req_o ? {addr_q[63:3], 3'b000} : '0;
    mem_be_o     = '0;
    if (mem_req_o) mem_be_o = dw_q ? 8'hFF : (addr_q[2] ? 8'hF0 : 8'h0F);
    mem_wdata_o  = mem_we_o ? wdata : '0;
    amo_ack_o    = (state_q == StAck);
    amo_result_o = '0;
    if (amo_ack_o) amo_result_o = (op_q == AMO_SC) ? {63'b0, sc_fail_q} : old_ext;
  end

endmodule

// File: tb/tb_amo_responder.sv
// Scoreboard bench for amo_responder: the driver pushes expected results and
// writes, a monitor checks acks and a memory model checks writes.
module tb_amo_responder;
  import amo_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        amo_req_i = 1'b0;
  amo_t        amo_op_i = AMO_NONE;
  logic [1:0]  amo_size_i = 2'b00;
  logic [63:0] amo_addr_i = '0;
  logic [63:0] amo_data_i = '0;
  logic        amo_ack_o;
  logic [63:0] amo_result_o;
  logic        mem_req_o, mem_we_o;
  logic [63:0] mem_addr_o, mem_wdata_o;
  logic [7:0]  mem_be_o;
  logic        mem_gnt_i = 1'b1;
  logic        mem_rvalid_i = 1'b0;
  logic [63:0] mem_rdata_i = '0;

  always #5 clk_i = ~clk_i;

  amo_responder dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .amo_req_i(amo_req_i), .amo_op_i(amo_op_i), .amo_size_i(amo_size_i),
    .amo_addr_i(amo_addr_i), .amo_data_i(amo_data_i),
    .amo_ack_o(amo_ack_o), .amo_result_o(amo_result_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  typedef struct {logic [63:0] res; int lat;} exp_t;
  typedef struct {logic [63:0] addr; logic [63:0] data; logic [7:0] be;} wr_t;

  exp_t exp_q[$];
  wr_t  wr_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   accept_cyc = 0;
  logic hold_rvalid = 1'b0;
  int   late_req = 0;
  int   stall_cfg = 0;
  int   stall_id = 0;
  int   mem_access = 0;
  logic [63:0] mem [0:2047];

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic exp_wr(input logic [63:0] addr, input logic [63:0] data, input logic [7:0] be);
    wr_q.push_back('{addr: addr, data: data, be: be});
  endtask

  task automatic do_amo(input amo_t op, input logic [1:0] size, input logic [63:0] addr,
                        input logic [63:0] data, input logic [63:0] res, input int lat);
    int n;
    @(posedge clk_i); #1;
    exp_q.push_back('{res: res, lat: lat});
    amo_op_i = op; amo_size_i = size; amo_addr_i = addr; amo_data_i = data;
    amo_req_i = 1'b1;
    accept_cyc = cyc;
    n = 0;
    while (!amo_ack_o && n < 60) begin
      @(posedge clk_i); #1;
      n++;
      // Inputs change after acceptance; the DUT must use its captured copy
      amo_data_i = ~data; amo_addr_i = addr ^ 64'hF00; amo_op_i = AMO_XOR;
    end
    if (n >= 60) begin
      checks++; failures++;
      $display("FAIL ack_timeout: op %s got no ack expected ack within 60 cycles", op.name());
    end
    amo_req_i = 1'b0;
  endtask

  // Monitor: compare every ack against the scoreboard, result must be zero otherwise
  initial forever begin
    exp_t e;
    @(negedge clk_i);
    if (amo_ack_o) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_ack: got result %h expected no ack", amo_result_o);
      end else begin
        e = exp_q.pop_front();
        chk64("ack_result", amo_result_o, e.res);
        chk64("ack_latency", 64'(cyc - accept_cyc), 64'(e.lat));
      end
    end else begin
      chk64("result_when_idle", amo_result_o, 64'h0);
    end
  end

  // Memory model: zero-wait grant (unless stalled), rvalid one cycle after a read grant
  initial begin
    int stall_left, stall_seen, late_done;
    logic g_valid, g_we, snap_valid;
    logic [63:0] g_addr, g_wdata;
    logic [7:0]  g_be;
    logic [137:0] snap, cur;
    wr_t w;
    stall_left = 0; stall_seen = 0; late_done = 0;
    g_valid = 1'b0; g_we = 1'b0; snap_valid = 1'b0;
    g_addr = '0; g_wdata = '0; g_be = '0; snap = '0;
    for (int i = 0; i < 2048; i++) mem[i] = '0;
    mem[11'h200] = 64'h10;
    mem[11'h220] = 64'h00000001_AAAAAAAA;
    mem[11'h240] = 64'h00000001_BBBBBBBB;
    mem[11'h400] = 64'h1234;
    mem[11'h600] = 64'h40;
    forever begin
      @(posedge clk_i); #1;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
      if (g_valid) begin
        mem_access++;
        if (g_we) begin
          if (wr_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_write: got addr %h data %h expected no write",
                     g_addr, g_wdata);
          end else begin
            w = wr_q.pop_front();
            chk64("wr_addr", g_addr, w.addr);
            chk64("wr_data", g_wdata, w.data);
            chk64("wr_be", 64'(g_be), 64'(w.be));
          end
          for (int b = 0; b < 8; b++)
            if (g_be[b]) mem[g_addr[13:3]][8*b +: 8] = g_wdata[8*b +: 8];
        end else if (!hold_rvalid) begin
          mem_rvalid_i = 1'b1;
          mem_rdata_i  = mem[g_addr[13:3]];
        end
      end
      if (late_req != late_done) begin
        late_done++;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 64'hDEAD_BEEF_DEAD_BEEF;
      end
      if (stall_id != stall_seen) begin
        stall_seen = stall_id;
        stall_left = stall_cfg;
      end
      mem_gnt_i = (stall_left == 0);
      if (stall_left > 0 && (mem_req_o || snap_valid)) begin
        cur = {mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o};
        if (!snap_valid) begin
          snap = cur;
          snap_valid = 1'b1;
        end else begin
          checks++;
          if (cur !== snap) begin
            failures++;
            $display("FAIL stall_hold: got %h expected %h", cur, snap);
          end
        end
        stall_left--;
      end else if (stall_left == 0) begin
        snap_valid = 1'b0;
      end
      @(negedge clk_i);
      g_valid = mem_req_o && mem_gnt_i && rst_ni;
      g_we    = mem_we_o;
      g_addr  = mem_addr_o;
      g_be    = mem_be_o;
      g_wdata = mem_wdata_o;
    end
  end

  initial begin
    int acc0;
    logic [63:0] m2000;
    repeat (3) @(posedge clk_i);
    #1;
    chk64("rst_ack", 64'(amo_ack_o), 64'h0);
    chk64("rst_mem_req", 64'(mem_req_o), 64'h0);
    chk64("rst_mem_we", 64'(mem_we_o), 64'h0);
    chk64("rst_result", amo_result_o, 64'h0);
    chk64("rst_mem_addr", mem_addr_o, 64'h0);
    chk64("rst_mem_be", 64'(mem_be_o), 64'h0);
    chk64("rst_mem_wdata", mem_wdata_o, 64'h0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    exp_wr(64'h1000, 64'h15, 8'hFF);
    do_amo(AMO_ADD, 2'b11, 64'h1000, 64'h5, 64'h10, 4);
    exp_wr(64'h1100, 64'h00000001_00000001, 8'hF0);
    do_amo(AMO_MAX, 2'b10, 64'h1104, 64'hFFFFFFFF, 64'h1, 4);
    exp_wr(64'h1200, 64'hFFFFFFFF_FFFFFFFF, 8'hF0);
    do_amo(AMO_MAXU, 2'b10, 64'h1204, 64'hFFFFFFFF, 64'h1, 4);
    exp_wr(64'h1100, 64'h0, 8'h0F);
    do_amo(AMO_ADD, 2'b10, 64'h1100, 64'h55555556, 64'hFFFFFFFF_AAAAAAAA, 4);
    exp_wr(64'h1100, 64'hFFFFFFFF_FFFFFFFF, 8'hF0);
    do_amo(AMO_MIN, 2'b10, 64'h1104, 64'hFFFFFFFF, 64'h1, 4);

    @(posedge clk_i); #2;
    acc0 = mem_access;
    do_amo(AMO_NONE, 2'b11, 64'h1000, 64'h77, 64'h0, 1);
    @(posedge clk_i); #2;
    chk64("none_no_mem_access", 64'(mem_access), 64'(acc0));

    do_amo(AMO_LR, 2'b11, 64'h2000, 64'h0, 64'h1234, 3);
`ifdef AMO_RESP_LRSC_EN
    exp_wr(64'h2000, 64'h7, 8'hFF);
    do_amo(AMO_SC, 2'b11, 64'h2000, 64'h7, 64'h0, 2);
    m2000 = 64'h7;
`else
    do_amo(AMO_SC, 2'b11, 64'h2000, 64'h7, 64'h1, 1);
    m2000 = 64'h1234;
`endif
    do_amo(AMO_SC, 2'b11, 64'h2000, 64'h8, 64'h1, 1);
    do_amo(AMO_LR, 2'b11, 64'h2000, 64'h0, m2000, 3);
    exp_wr(64'h2000, 64'h99, 8'hFF);
    do_amo(AMO_SWAP, 2'b11, 64'h2000, 64'h99, m2000, 4);
    do_amo(AMO_SC, 2'b11, 64'h2000, 64'hAB, 64'h1, 1);

    stall_cfg = 5;
    stall_id++;
    exp_wr(64'h3000, 64'hBF, 8'hFF);
    do_amo(AMO_XOR, 2'b11, 64'h3000, 64'hFF, 64'h40, 9);

    // Reset while waiting for read data: transaction is dropped, late rvalid ignored
    hold_rvalid = 1'b1;
    @(posedge clk_i); #1;
    amo_op_i = AMO_ADD; amo_size_i = 2'b11; amo_addr_i = 64'h3000; amo_data_i = 64'h1;
    amo_req_i = 1'b1;
    @(posedge clk_i); #1;
    amo_req_i = 1'b0;
    @(posedge clk_i); #1;
    rst_ni = 1'b0;
    #1;
    chk64("midrst_ack", 64'(amo_ack_o), 64'h0);
    chk64("midrst_mem_req", 64'(mem_req_o), 64'h0);
    chk64("midrst_mem_we", 64'(mem_we_o), 64'h0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    late_req++;
    hold_rvalid = 1'b0;
    repeat (4) begin
      @(posedge clk_i); #1;
      chk64("postrst_ack", 64'(amo_ack_o), 64'h0);
      chk64("postrst_mem_req", 64'(mem_req_o), 64'h0);
    end

    exp_wr(64'h3000, 64'h1BF, 8'hFF);
    do_amo(AMO_OR, 2'b11, 64'h3000, 64'h100, 64'hBF, 4);
    exp_wr(64'h3000, 64'h0F, 8'hFF);
    do_amo(AMO_AND, 2'b11, 64'h3000, 64'h0F, 64'h1BF, 4);

    repeat (5) @(posedge clk_i);
    chk64("ack_queue_drained", 64'(exp_q.size()), 64'h0);
    chk64("write_queue_drained", 64'(wr_q.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
